// File: rtl/pla_vector_sweeper.sv
// Exhaustive 8-input stimulus driver and MISR/ones-count response compactor for single-output cones.
// Optional truth-table capture with read port is enabled by defining PLA_SWEEP_TT_CAPTURE_EN.
`timescale 1ns/1ps

module pla_vector_sweeper #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] MISR_POLY     = 16'h1021,
  parameter logic [15:0] MISR_SEED     = 16'h0000,
  parameter logic [15:0] EXPECTED_SIG  = 16'h0000,
  parameter logic [8:0]  EXPECTED_ONES = 9'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  vec,
  input  logic        dut_y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] sig,
  output logic [8:0]  ones_cnt
`ifdef PLA_SWEEP_TT_CAPTURE_EN
  ,
  input  logic [7:0]  tt_addr,
  output logic        tt_bit
`endif
);

  // state  | meaning
  // IDLE   | waiting for start
  // DRIVE  | vec applied to the cone, settle counter running
  // SAMPLE | dut_y folded into sig / ones_cnt, advance vec
  // DONE   | sweep complete, results frozen, pass valid
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  settle_cnt;
  logic        settle_last;
  logic        last_vec;
  logic        run_start;
  logic        sample_en;
  logic [15:0] sig_next;

  assign settle_last = (settle_cnt == SETTLE_LAST);
  assign last_vec    = (vec == 8'hFF);
  assign sig_next    = {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {15'b0, dut_y};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    run_start  = 1'b0;
    sample_en  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            run_start  = 1'b1;
            state_next = DRIVE;
          end
        end
        DRIVE: begin
          if (settle_last) begin
            state_next = SAMPLE;
          end
        end
        SAMPLE: begin
          sample_en  = 1'b1;
          state_next = last_vec ? DONE : DRIVE;
        end
        DONE: begin
          if (start) begin
            run_start  = 1'b1;
            state_next = DRIVE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    busy = (state == DRIVE) || (state == SAMPLE);
    done = (state == DONE);
  end

  assign pass = done && (sig == EXPECTED_SIG) && (ones_cnt == EXPECTED_ONES);

  // Abort keeps the partial sig/ones_cnt visible for debug; only a new run clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= 8'h00;
      sig        <= MISR_SEED;
      ones_cnt   <= 9'd0;
      settle_cnt <= 4'd0;
    end else if (abort) begin
      vec        <= 8'h00;
      settle_cnt <= 4'd0;
    end else if (run_start) begin
      vec        <= 8'h00;
      sig        <= MISR_SEED;
      ones_cnt   <= 9'd0;
      settle_cnt <= 4'd0;
    end else if (state == DRIVE) begin
      settle_cnt <= settle_cnt + 4'd1;
    end else if (sample_en) begin
      sig        <= sig_next;
      ones_cnt   <= ones_cnt + {8'b0, dut_y};
      settle_cnt <= 4'd0;
      if (!last_vec) begin
        vec <= vec + 8'd1;
      end
    end
  end

`ifdef PLA_SWEEP_TT_CAPTURE_EN
  logic [255:0] tt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt <= '0;
    end else if (run_start) begin
      tt <= '0;
    end else if (sample_en) begin
      tt[vec] <= dut_y;
    end
  end

  assign tt_bit = tt[tt_addr];
`endif

endmodule

// File: tb/tb_pla_vector_sweeper.sv
// Directed bench for pla_vector_sweeper: table of full sweeps plus reset/abort/start corner sequences.
`timescale 1ns/1ps

module tb_pla_vector_sweeper;

  localparam int SETTLE       = 2;
  localparam int SWEEP_CYCLES = 256 * (SETTLE + 1);
  localparam int BUDGET       = SWEEP_CYCLES + 64;

  function automatic logic model_y(input int mode, input logic [7:0] v);
    case (mode)
      0:       return 1'b0;
      1:       return v[0];
      2:       return 1'b1;
      3:       return (v == 8'h5A);
      4:       return v[7] ^ v[3];
      5:       return (v < 8'h10);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic y);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    r[0] = r[0] ^ y;
    return r;
  endfunction

  function automatic logic [15:0] model_sig(input int mode, input int nvec);
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 0; i < nvec; i++) s = misr_step(s, model_y(mode, 8'(i)));
    return s;
  endfunction

  localparam logic [15:0] SIG_ALL_ONES = model_sig(2, 256);

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  vec;
  logic        dut_y;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] sig;
  logic [8:0]  ones_cnt;
  int          y_mode;

  logic        start2;
  logic        abort2;
  logic [7:0]  vec2;
  logic        dut_y2;
  logic        busy2;
  logic        done2;
  logic        pass2;
  logic [15:0] sig2;
  logic [8:0]  ones2;

`ifdef PLA_SWEEP_TT_CAPTURE_EN
  logic [7:0]  tt_addr;
  logic        tt_bit;
  logic [7:0]  tt_addr2;
  logic        tt_bit2;
`endif

  int n_vec;
  int n_miss;

  pla_vector_sweeper #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec(vec), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .sig(sig), .ones_cnt(ones_cnt)
`ifdef PLA_SWEEP_TT_CAPTURE_EN
    , .tt_addr(tt_addr), .tt_bit(tt_bit)
`endif
  );

  pla_vector_sweeper #(
    .SETTLE_CYCLES(SETTLE), .EXPECTED_SIG(SIG_ALL_ONES), .EXPECTED_ONES(9'd256)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .vec(vec2), .dut_y(dut_y2),
    .busy(busy2), .done(done2), .pass(pass2), .sig(sig2), .ones_cnt(ones2)
`ifdef PLA_SWEEP_TT_CAPTURE_EN
    , .tt_addr(tt_addr2), .tt_bit(tt_bit2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb dut_y = model_y(y_mode, vec);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_sweep(input int mode, output int lat);
    y_mode = mode;
    pulse_start();
    check("start_busy", busy, 1'b1);
    check("start_done_drop", done, 1'b0);
    lat = -1;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic wait_vec(input logic [7:0] target, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (vec == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int          mode;
    logic [8:0]  exp_ones;
    logic [15:0] exp_sig;
    logic        exp_pass;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat;
    bit ok;
    n_vec  = 0;
    n_miss = 0;
    tbl[0] = '{0, 9'd0,   16'h0000,          1'b1};
    tbl[1] = '{1, 9'd128, model_sig(1, 256), 1'b0};
    tbl[2] = '{4, 9'd128, model_sig(4, 256), 1'b0};
    tbl[3] = '{5, 9'd16,  model_sig(5, 256), 1'b0};
    tbl[4] = '{3, 9'd1,   model_sig(3, 256), 1'b0};
    tbl[5] = '{2, 9'd256, SIG_ALL_ONES,      1'b0};

    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    start2 = 1'b0;
    abort2 = 1'b0;
    dut_y2 = 1'b1;
    y_mode = 0;
`ifdef PLA_SWEEP_TT_CAPTURE_EN
    tt_addr  = 8'h00;
    tt_addr2 = 8'h00;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec", vec, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_sig", sig, 16'h0000);
    check("rst_ones", ones_cnt, 9'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      run_sweep(tbl[t].mode, lat);
      check($sformatf("tbl%0d_latency", t), lat, SWEEP_CYCLES);
      check($sformatf("tbl%0d_ones", t), ones_cnt, tbl[t].exp_ones);
      check($sformatf("tbl%0d_sig", t), sig, tbl[t].exp_sig);
      check($sformatf("tbl%0d_pass", t), pass, tbl[t].exp_pass);
      check($sformatf("tbl%0d_vec", t), vec, 8'hFF);
      check($sformatf("tbl%0d_busy", t), busy, 1'b0);
`ifdef PLA_SWEEP_TT_CAPTURE_EN
      if (tbl[t].mode == 3) begin
        for (int a = 0; a < 256; a++) begin
          tt_addr = 8'(a);
          #1;
          check($sformatf("tt_bit_%0h", a), tt_bit, (a == 8'h5A) ? 1'b1 : 1'b0);
        end
      end
`endif
    end

    // abort in DONE clears done and pass but keeps results
    run_sweep(0, lat);
    check("pass_before_abort", pass, 1'b1);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_done_clear", done, 1'b0);
    check("abort_pass_clear", pass, 1'b0);
    check("abort_vec_zero", vec, 8'h00);

`ifdef PLA_SWEEP_TT_CAPTURE_EN
    run_sweep(3, lat);
    y_mode = 0;
    pulse_start();
    tt_addr = 8'h5A;
    #1;
    check("tt_cleared_on_start", tt_bit, 1'b0);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
`endif

    // start while busy is ignored
    y_mode = 1;
    pulse_start();
    repeat (100) @(posedge clk);
    pulse_start();
    lat = -1;
    for (int n = 102; n <= BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    check("busy_start_latency", lat, SWEEP_CYCLES);
    check("busy_start_ones", ones_cnt, 9'd128);
    check("busy_start_sig", sig, model_sig(1, 256));

    // abort with start while busy, then a fresh sweep
    y_mode = 1;
    pulse_start();
    wait_vec(8'h20, ok);
    check("reach_vec20", ok, 1'b1);
    check("partial_ones", ones_cnt, 9'd16);
    check("partial_sig", sig, model_sig(1, 32));
    @(negedge clk) begin
      abort = 1'b1;
      start = 1'b1;
    end
    @(posedge clk);
    #1 begin
      abort = 1'b0;
      start = 1'b0;
    end
    check("abort_start_busy", busy, 1'b0);
    check("abort_start_done", done, 1'b0);
    check("abort_start_vec", vec, 8'h00);
    check("abort_keep_ones", ones_cnt, 9'd16);
    check("abort_keep_sig", sig, model_sig(1, 32));
    repeat (10) @(posedge clk);
    #1;
    check("abort_stays_idle", busy, 1'b0);
    run_sweep(1, lat);
    check("fresh_latency", lat, SWEEP_CYCLES);
    check("fresh_ones", ones_cnt, 9'd128);
    check("fresh_sig", sig, model_sig(1, 256));

    // asynchronous reset mid-DRIVE at vec 0x40
    y_mode = 1;
    pulse_start();
    wait_vec(8'h40, ok);
    check("reach_vec40", ok, 1'b1);
    check("pre_rst_ones", ones_cnt, 9'd32);
    check("pre_rst_sig", sig, model_sig(1, 64));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_vec", vec, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_sig", sig, 16'h0000);
    check("midrst_ones", ones_cnt, 9'd0);
    check("midrst_done", done, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // all-ones cone with matching golden values
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    check("ones2_busy", busy2, 1'b1);
    lat = -1;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (done2) begin
        lat = n;
        break;
      end
    end
    check("ones2_latency", lat, SWEEP_CYCLES);
    check("ones2_pass", pass2, 1'b1);
    check("ones2_vec", vec2, 8'hFF);
    check("ones2_cnt", ones2, 9'd256);
    check("ones2_sig", sig2, SIG_ALL_ONES);
`ifdef PLA_SWEEP_TT_CAPTURE_EN
    tt_addr2 = 8'hFF;
    #1;
    check("ones2_tt", tt_bit2, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pla_vector_sweeper.md
Name: pla_vector_sweeper

Overview:
- Sequential stimulus driver and response compactor for the 8-input, 1-output combinational cones in the benchmark set.
- On `start`, drives all 256 input vectors to the cone under test in ascending order and samples the cone output for each vector.
- Compacts the responses into a 16-bit MISR signature and a ones count, then flags pass/fail against expected values.
- Sits between the test controller and any single-output cone netlist; it is the stimulus/observe end of the cone's x0..x7 -> y0 interface.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling (legal 1..15).
- MISR_POLY, 16'h1021, feedback taps of the signature register.
- MISR_SEED, 16'h0000, signature value loaded at run start.
- EXPECTED_SIG, 16'h0000, golden signature for the pass check.
- EXPECTED_ONES, 9'd0, golden ones count for the pass check.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- abort  in  1  returns to IDLE from any state; takes priority over start.
- vec  out  8  stimulus to cone inputs, x0 = vec[0] ... x7 = vec[7].
- dut_y  in  1  cone output y0.
- busy  out  1  high in DRIVE/SAMPLE.
- done  out  1  high in DONE; held until the next start or abort.
- pass  out  1  valid while done: (sig == EXPECTED_SIG) && (ones_cnt == EXPECTED_ONES); 0 otherwise.
- sig  out  16  MISR signature, live during the run and final in DONE.
- ones_cnt  out  9  number of vectors with dut_y = 1 (0..256).

Behaviour:
- Reset (asynchronous, any state, including mid-sweep):
  - State = IDLE, vec = 0, busy = 0, done = 0, pass = 0.
  - sig = MISR_SEED, ones_cnt = 0, settle counter = 0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - On start: vec <= 0, sig <= MISR_SEED, ones_cnt <= 0, settle counter <= 0, go to DRIVE.
- DRIVE:
  - vec held constant; settle counter increments each cycle.
  - When the counter reaches SETTLE_CYCLES-1, go to SAMPLE.
  - With SETTLE_CYCLES = 1, DRIVE lasts exactly one cycle.
- SAMPLE (one cycle):
  - dut_y is captured this cycle.
  - sig <= (sig << 1) ^ (sig[15] ? MISR_POLY : 0) ^ {15'b0, dut_y}.
  - ones_cnt += dut_y.
  - If vec == 8'hFF: go to DONE; vec stays 8'hFF.
  - Otherwise: vec <= vec + 1, counter cleared, go to DRIVE.
- DONE:
  - done = 1; pass evaluated combinationally from the final sig/ones_cnt; outputs frozen.
  - On start: restart exactly as from IDLE (done drops the cycle after start).
- Timing:
  - vec changes only on the DRIVE entry edge, so the cone sees each vector for SETTLE_CYCLES+1 cycles including the sample cycle.
  - Sweep latency, start edge to done high: 256*(SETTLE_CYCLES+1) cycles (768 at default).
- Boundary cases:
  - start while busy: ignored.
  - start and abort in the same cycle: abort wins, state = IDLE.
  - abort: clears busy/done; vec <= 0; sig and ones_cnt keep their partial values until the next start.
  - ones_cnt is 9 bits so that 256 is representable; no wrap.
  - vec wrap from FF->00 never occurs inside a run.
  - dut_y is sampled only in SAMPLE; its value in other states is ignored.

Optional Feature:
- Macro: PLA_SWEEP_TT_CAPTURE_EN.
- When defined:
  - Adds a 256x1 truth-table register written in SAMPLE at index vec.
  - Adds read ports tt_addr (in, 8) and tt_bit (out, 1); tt_bit = tt[tt_addr] combinationally.
  - Table cleared on reset and on each start.
  - Reads are valid in any state; entries not yet swept read 0.
- When undefined:
  - Ports and storage are absent; all other behaviour is identical.

Test Plan:
- dut_y tied 0, defaults -> done after 768 cycles; sig = 16'h0000, ones_cnt = 0, pass = 1.
- dut_y = vec[0] -> ones_cnt = 128; sig matches the model MISR; pass = 0 with default EXPECTED_ONES.
- dut_y tied 1, EXPECTED_ONES = 256, EXPECTED_SIG = model value -> pass = 1; vec = 8'hFF in DONE.
- rst_n low at vec = 8'h40 mid-DRIVE -> immediate IDLE, vec = 0, busy = 0, sig = seed.
- abort asserted with start in the same cycle while busy -> IDLE next edge, done = 0; a later start gives a full fresh sweep with identical results.
- PLA_SWEEP_TT_CAPTURE_EN defined, dut_y = (vec == 8'h5A) -> tt_bit = 1 only at tt_addr 8'h5A; ones_cnt = 1.
